dsi_lane_array: RTL and testbench
=================================

# dsi_lane_array

Multi-lane, parametrised MIPI D-PHY data-lane sequencer for the DSI transmitter. It sits between the packet assembler and the per-lane serializers/IO buffers. It accepts LANES bytes per beat through a ready/valid FIFO and drives the full LP-11 → HS-request → HS-zero → SYNC → payload → trail → LP-11 sequence on all lanes in lockstep, using run-time-programmable timing. It adds underrun detection and per-lane trail generation.

## Interface
- LANES, 2 — number of data lanes, 1..4
- FIFO_DEPTH, 4 — input FIFO entries, power of two, ≥2
- TW, 8 — width of timing inputs/counter
- clk_base  in  1  byte clock (serial clock / 8)
- reset_n  in  1  reset, asynchronous, active-low
- s_valid  in  1  input beat valid
- s_ready  out  1  FIFO can accept a beat (= !full)
- s_data  in  8*LANES  lane k byte in bits [8k+7:8k]
- s_last  in  1  final beat of HS burst
- t_lpx, t_prep, t_zero, t_trail, t_exit  in  TW each  state durations in clk_base cycles
- hs_data  out  8*LANES  parallel byte per lane to serializer, MSB transmitted first
- hs_oe  out  1  HS driver enable, all lanes
- lp_p, lp_n  out  1 each  LP line levels, common to all lanes
- lp_oe  out  1  LP driver enable
- busy  out  1  state != STOP
- underrun  out  1  one-cycle pulse on FIFO empty during DATA

## Operation
- FIFO word = {last, data}; push on s_valid && s_ready; pop only in DATA, one per cycle.
- States: STOP, LPX, PREP, ZERO, SYNC, DATA, TRAIL, EXIT.
- STOP → LPX when FIFO non-empty; timing inputs latched on this transition; changes mid-burst are ignored.
- Timed states (LPX, PREP, ZERO, TRAIL, EXIT) last max(t,1) cycles; counter cleared on every state entry.
- ZERO → SYNC (exactly 1 cycle) → DATA.
- DATA: pop a beat each cycle; the popped beat is hs_data the same cycle. Popped last=1 → TRAIL next.
- DATA with FIFO empty: hs_data = trail bytes, underrun pulses, go to TRAIL; the rest of the packet is flushed on next entry? No: the remaining beats start a new burst.
- Trail byte lane k = {8{~b0}}, where b0 is bit 0 of the last byte sent on lane k.
- EXIT → STOP.
- Outputs are Moore, decoded from the state register:
  - STOP/EXIT: lp=11, lp_oe=1, hs_oe=0
  - LPX: lp_p=0, lp_n=1, lp_oe=1
  - PREP: lp=00, lp_oe=1
  - ZERO: hs_data=0, hs_oe=1, lp_oe=0
  - SYNC: each lane 8'b00011101, hs_oe=1
  - DATA/TRAIL: hs_oe=1
- hs_data = 0 whenever hs_oe=0.
- Simultaneous push and pop while full: the push is refused because s_ready is already low; there is no bypass.

## Timing
- Reset values: state STOP, FIFO empty, s_ready=1, hs_data=0, hs_oe=0, lp_p=lp_n=1, lp_oe=1, busy=0, underrun=0, trail bytes 0xFF. Applied asynchronously; reset mid-burst flushes the FIFO.
- Push at edge 0 → LPX begins at edge 1.
- Total burst = lpx+prep+zero+1+N+trail+exit cycles for N beats without underrun.
- s_ready reflects occupancy after the previous edge, with no combinational path from s_valid.

## Configuration
- DSI_LANE_STATS_EN:
  - Defined: adds outputs burst_count [15:0] (increments on EXIT → STOP) and beat_count [31:0] (increments per DATA pop). Both wrap, and both reset to 0.
  - Undefined: these ports and counters are absent; all other behaviour is identical.

## Structure
- Package dsi_pkg holds:
  - state enum
  - SYNC_PATTERN = 8'b00011101
  - LP level constants LP11/LP01/LP00
- Sub-module dsi_lane_fifo: synchronous FIFO, parameter WIDTH = 8*LANES+1 and DEPTH, ports push/pop/full/empty. Serializers and IO buffers stay outside this block.

## Test plan
- LANES=2, t_lpx=2, t_prep=1, t_zero=3, t_trail=2, t_exit=2; single beat 0x12_34 with last → LPX cycles 1-2, PREP 3, ZERO 4-6, SYNC 7 (0x1D_1D), DATA 8 (0x1234), TRAIL 9-10 (0xFF_FF, since b0=0 on both lanes), EXIT 11-12, STOP 13.
- 6-beat burst with s_valid held, FIFO_DEPTH=4 → s_ready drops when 4 entries are queued; all 6 beats appear in order; no underrun.
- Upstream stalls after beat 2 of 5 → underrun pulses once; TRAIL follows; remaining beats start a second burst with a full LPX..SYNC preamble.
- All timing inputs = 0 → each timed state lasts exactly 1 cycle.
- Assert reset_n mid-DATA → outputs immediately at reset values; FIFO empty; next push restarts from LPX.
- Change t_zero during ZERO → current burst uses the latched value; the next burst uses the new one.

Source files
------------

// File: rtl/dsi_pkg.sv
// -----------------------------------------------------------------------------
// dsi_pkg
// Shared definitions for the DSI D-PHY data-lane sequencer.
//   dsi_state_e  : lane sequencer states (STOP .. EXIT)
//   SYNC_PATTERN : HS sync byte sent on every lane in SYNC
//   LP11/LP01/LP00 : LP line levels packed as {lp_p, lp_n}
// -----------------------------------------------------------------------------
package dsi_pkg;

    typedef enum logic [2:0] {
        ST_STOP  = 3'd0,
        ST_LPX   = 3'd1,
        ST_PREP  = 3'd2,
        ST_ZERO  = 3'd3,
        ST_SYNC  = 3'd4,
        ST_DATA  = 3'd5,
        ST_TRAIL = 3'd6,
        ST_EXIT  = 3'd7
    } dsi_state_e;

    localparam logic [7:0] SYNC_PATTERN = 8'b00011101;

    // {lp_p, lp_n}
    localparam logic [1:0] LP11 = 2'b11;
    localparam logic [1:0] LP01 = 2'b01;
    localparam logic [1:0] LP00 = 2'b00;

endpackage

// File: rtl/dsi_lane_fifo.sv
// -----------------------------------------------------------------------------
// dsi_lane_fifo
// Synchronous FIFO holding {last, lane bytes} beats for the lane sequencer.
// The head entry is presented combinationally on rd_data while not empty.
// Ports:
//   clk_base, reset_n : clock, asynchronous active-low reset (pointers only)
//   push, wr_data     : write strobe and word (ignored while full)
//   pop, rd_data      : read strobe (ignored while empty) and head word
//   full, empty       : occupancy flags
// -----------------------------------------------------------------------------
module dsi_lane_fifo
    import dsi_pkg::*;
#(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic             clk_base,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk_base or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which
    // entries are valid, and leaving the array reset-free lets it map to RAM.
    always_ff @(posedge clk_base) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/dsi_lane_array.sv
// -----------------------------------------------------------------------------
// dsi_lane_array
// Multi-lane MIPI D-PHY data-lane sequencer. Beats of LANES bytes enter a
// ready/valid FIFO; all lanes run LP-11 -> LPX -> PREP -> ZERO -> SYNC ->
// DATA -> TRAIL -> EXIT -> LP-11 in lockstep with run-time timing that is
// latched at burst start. Running dry in DATA ends the burst with trail bytes
// and an underrun pulse; the leftover beats start a fresh burst.
// Ports:
//   clk_base, reset_n        : byte clock, asynchronous active-low reset
//   s_valid/s_ready/s_data/s_last : input beat stream (s_ready = !full)
//   t_lpx .. t_exit          : timed-state durations, 0 behaves as 1
//   hs_data, hs_oe           : parallel HS bytes per lane, HS driver enable
//   lp_p, lp_n, lp_oe        : common LP line levels and LP driver enable
//   busy                     : sequencer not in STOP
//   underrun                 : one-cycle pulse, FIFO empty during DATA
//   burst_count, beat_count  : only with DSI_LANE_STATS_EN defined
// Configuration macro: DSI_LANE_STATS_EN adds wrapping burst/beat counters.
// -----------------------------------------------------------------------------
module dsi_lane_array
    import dsi_pkg::*;
#(
    parameter int LANES      = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int TW         = 8
) (
    input  logic                 clk_base,
    input  logic                 reset_n,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [8*LANES-1:0]   s_data,
    input  logic                 s_last,
    input  logic [TW-1:0]        t_lpx,
    input  logic [TW-1:0]        t_prep,
    input  logic [TW-1:0]        t_zero,
    input  logic [TW-1:0]        t_trail,
    input  logic [TW-1:0]        t_exit,
    output logic [8*LANES-1:0]   hs_data,
    output logic                 hs_oe,
    output logic                 lp_p,
    output logic                 lp_n,
    output logic                 lp_oe,
    output logic                 busy,
    output logic                 underrun
`ifdef DSI_LANE_STATS_EN
    ,
    output logic [15:0]          burst_count,
    output logic [31:0]          beat_count
`endif
);

    localparam int DW = 8*LANES;

    dsi_state_e    state;
    dsi_state_e    state_nx;
    logic [TW-1:0] cnt;
    logic [TW-1:0] cur_t;
    logic [TW:0]   cnt_inc;
    logic          timer_done;

    logic [TW-1:0] lat_lpx, lat_prep, lat_zero, lat_trail, lat_exit;

    logic [DW:0]   fifo_rd;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          start;
    logic [DW-1:0] trail_bytes;
    logic [1:0]    lp_lvl;

    // ---------------------------------------------------------------- FIFO
    assign s_ready = !fifo_full;
    assign push    = s_valid && !fifo_full;
    assign pop     = (state == ST_DATA) && !fifo_empty;

    dsi_lane_fifo #(
        .WIDTH (DW + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_base (clk_base),
        .reset_n  (reset_n),
        .push     (push),
        .wr_data  ({s_last, s_data}),
        .pop      (pop),
        .rd_data  (fifo_rd),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // ------------------------------------------------------- timing latch
    assign start = (state == ST_STOP) && !fifo_empty;

    always_ff @(posedge clk_base or negedge reset_n) begin
        if (!reset_n) begin
            lat_lpx   <= '0;
            lat_prep  <= '0;
            lat_zero  <= '0;
            lat_trail <= '0;
            lat_exit  <= '0;
        end else if (start) begin
            lat_lpx   <= t_lpx;
            lat_prep  <= t_prep;
            lat_zero  <= t_zero;
            lat_trail <= t_trail;
            lat_exit  <= t_exit;
        end
    end

    // Duration of the current timed state; done when cnt+1 >= t, which makes
    // both t=0 and t=1 last exactly one cycle.
    always_comb begin
        cur_t = '0;
        unique case (state)
            ST_LPX:   cur_t = lat_lpx;
            ST_PREP:  cur_t = lat_prep;
            ST_ZERO:  cur_t = lat_zero;
            ST_TRAIL: cur_t = lat_trail;
            ST_EXIT:  cur_t = lat_exit;
            default:  cur_t = '0;
        endcase
    end

    assign cnt_inc    = {1'b0, cnt} + (TW+1)'(1);
    assign timer_done = (cnt_inc >= {1'b0, cur_t});

    // -------------------------------------------------- state register
    always_ff @(posedge clk_base or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_STOP;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= (state_nx != state) ? '0 : cnt + TW'(1);
        end
    end

    // -------------------------------------------------- next state
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_STOP:  if (!fifo_empty) state_nx = ST_LPX;
            ST_LPX:   if (timer_done)  state_nx = ST_PREP;
            ST_PREP:  if (timer_done)  state_nx = ST_ZERO;
            ST_ZERO:  if (timer_done)  state_nx = ST_SYNC;
            ST_SYNC:                   state_nx = ST_DATA;
            ST_DATA:  if (fifo_empty || fifo_rd[DW]) state_nx = ST_TRAIL;
            ST_TRAIL: if (timer_done)  state_nx = ST_EXIT;
            ST_EXIT:  if (timer_done)  state_nx = ST_STOP;
            default:                   state_nx = ST_STOP;
        endcase
    end

    // Trail byte per lane is the inverse of bit 0 of the last byte sent there.
    always_ff @(posedge clk_base or negedge reset_n) begin
        if (!reset_n) begin
            trail_bytes <= '1;
        end else if (pop) begin
            for (int k = 0; k < LANES; k++) begin
                trail_bytes[8*k +: 8] <= {8{~fifo_rd[8*k]}};
            end
        end
    end

    // -------------------------------------------------- outputs
    // NOTE: every output gets a default before the case so no path through
    // this block leaves a signal unassigned and infers a latch.
    always_comb begin
        hs_data = '0;
        hs_oe   = 1'b0;
        lp_lvl  = LP00;
        lp_oe   = 1'b0;
        unique case (state)
            ST_STOP, ST_EXIT: begin
                lp_lvl = LP11;
                lp_oe  = 1'b1;
            end
            ST_LPX: begin
                lp_lvl = LP01;
                lp_oe  = 1'b1;
            end
            ST_PREP: begin
                lp_lvl = LP00;
                lp_oe  = 1'b1;
            end
            ST_ZERO: begin
                hs_oe = 1'b1;
            end
            ST_SYNC: begin
                hs_data = {LANES{SYNC_PATTERN}};
                hs_oe   = 1'b1;
            end
            ST_DATA: begin
                hs_data = fifo_empty ? trail_bytes : fifo_rd[DW-1:0];
                hs_oe   = 1'b1;
            end
            ST_TRAIL: begin
                hs_data = trail_bytes;
                hs_oe   = 1'b1;
            end
            default: begin
                lp_lvl = LP11;
                lp_oe  = 1'b1;
            end
        endcase
    end

    assign lp_p     = lp_lvl[1];
    assign lp_n     = lp_lvl[0];
    assign busy     = (state != ST_STOP);
    assign underrun = (state == ST_DATA) && fifo_empty;

`ifdef DSI_LANE_STATS_EN
    always_ff @(posedge clk_base or negedge reset_n) begin
        if (!reset_n) begin
            burst_count <= '0;
            beat_count  <= '0;
        end else begin
            if (state == ST_EXIT && state_nx == ST_STOP)
                burst_count <= burst_count + 16'd1;
            if (pop)
                beat_count <= beat_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dsi_lane_array.sv
// -----------------------------------------------------------------------------
// tb_dsi_lane_array
// Self-checking bench for dsi_lane_array (LANES=2, FIFO_DEPTH=4, TW=8).
// A queue-based reference model tracks the burst phase and remaining cycles;
// a compare process checks every output on each falling edge, and directed
// scenarios add literal expectations taken from hand-worked timelines.
// -----------------------------------------------------------------------------
module tb_dsi_lane_array;

    localparam int LANES = 2;
    localparam int DEPTH = 4;
    localparam int TW    = 8;
    localparam int DW    = 8*LANES;

    // Model phases
    localparam int P_STOP  = 0;
    localparam int P_LPX   = 1;
    localparam int P_PREP  = 2;
    localparam int P_ZERO  = 3;
    localparam int P_SYNC  = 4;
    localparam int P_DATA  = 5;
    localparam int P_TRAIL = 6;
    localparam int P_EXIT  = 7;

    logic          clk_base = 1'b0;
    logic          reset_n  = 1'b0;
    logic          s_valid  = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data   = '0;
    logic          s_last   = 1'b0;
    logic [TW-1:0] t_lpx    = 8'd2;
    logic [TW-1:0] t_prep   = 8'd1;
    logic [TW-1:0] t_zero   = 8'd3;
    logic [TW-1:0] t_trail  = 8'd2;
    logic [TW-1:0] t_exit   = 8'd2;
    logic [DW-1:0] hs_data;
    logic          hs_oe;
    logic          lp_p;
    logic          lp_n;
    logic          lp_oe;
    logic          busy;
    logic          underrun;

    int checks = 0;
    int errors = 0;

    always #5 clk_base = ~clk_base;

    dsi_lane_array #(
        .LANES      (LANES),
        .FIFO_DEPTH (DEPTH),
        .TW         (TW)
    ) dut (
        .clk_base (clk_base),
        .reset_n  (reset_n),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_last   (s_last),
        .t_lpx    (t_lpx),
        .t_prep   (t_prep),
        .t_zero   (t_zero),
        .t_trail  (t_trail),
        .t_exit   (t_exit),
        .hs_data  (hs_data),
        .hs_oe    (hs_oe),
        .lp_p     (lp_p),
        .lp_n     (lp_n),
        .lp_oe    (lp_oe),
        .busy     (busy),
        .underrun (underrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------- model
    logic [DW:0]    mq[$];
    int             ph = P_STOP;
    int             left = 0;
    int             lat[5];
    logic [LANES-1:0] lb0 = '0;   // bit 0 of last byte sent per lane
    logic           m_push;
    logic [DW:0]    m_beat;

    function automatic int dur(input int t);
        return (t == 0) ? 1 : t;
    endfunction

    always @(posedge clk_base or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
            ph   = P_STOP;
            left = 0;
            lb0  = '0;
        end else begin
            m_push = s_valid && (mq.size() < DEPTH);
            case (ph)
                P_STOP: if (mq.size() > 0) begin
                    lat[0] = int'(t_lpx);
                    lat[1] = int'(t_prep);
                    lat[2] = int'(t_zero);
                    lat[3] = int'(t_trail);
                    lat[4] = int'(t_exit);
                    ph = P_LPX; left = dur(lat[0]);
                end
                P_LPX:   begin left--; if (left == 0) begin ph = P_PREP; left = dur(lat[1]); end end
                P_PREP:  begin left--; if (left == 0) begin ph = P_ZERO; left = dur(lat[2]); end end
                P_ZERO:  begin left--; if (left == 0) ph = P_SYNC; end
                P_SYNC:  ph = P_DATA;
                P_DATA: begin
                    if (mq.size() == 0) begin
                        ph = P_TRAIL; left = dur(lat[3]);
                    end else begin
                        m_beat = mq.pop_front();
                        for (int k = 0; k < LANES; k++) lb0[k] = m_beat[8*k];
                        if (m_beat[DW]) begin ph = P_TRAIL; left = dur(lat[3]); end
                    end
                end
                P_TRAIL: begin left--; if (left == 0) begin ph = P_EXIT; left = dur(lat[4]); end end
                P_EXIT:  begin left--; if (left == 0) ph = P_STOP; end
                default: ph = P_STOP;
            endcase
            if (m_push) mq.push_back({s_last, s_data});
        end
    end

    // ---------------------------------------------------------- compare
    logic [DW-1:0] e_hs;
    logic [DW-1:0] e_trail;
    logic          e_hs_oe, e_lp_oe, e_lp_p, e_lp_n, e_under;
    int            und_total = 0;

    always @(negedge clk_base) begin
        for (int k = 0; k < LANES; k++) e_trail[8*k +: 8] = {8{~lb0[k]}};
        e_hs = '0; e_hs_oe = 1'b0; e_lp_oe = 1'b0; e_lp_p = 1'b0; e_lp_n = 1'b0; e_under = 1'b0;
        case (ph)
            P_STOP, P_EXIT: begin e_lp_oe = 1; e_lp_p = 1; e_lp_n = 1; end
            P_LPX:   begin e_lp_oe = 1; e_lp_n = 1; end
            P_PREP:  e_lp_oe = 1;
            P_ZERO:  e_hs_oe = 1;
            P_SYNC:  begin e_hs_oe = 1; e_hs = {LANES{8'h1D}}; end
            P_DATA: begin
                e_hs_oe = 1;
                if (mq.size() == 0) begin e_hs = e_trail; e_under = 1; end
                else e_hs = mq[0][DW-1:0];
            end
            P_TRAIL: begin e_hs_oe = 1; e_hs = e_trail; end
            default: ;
        endcase
        check("hs_data",  32'(hs_data), 32'(e_hs));
        check("hs_oe",    32'(hs_oe),   32'(e_hs_oe));
        check("lp_oe",    32'(lp_oe),   32'(e_lp_oe));
        if (e_lp_oe) begin
            check("lp_p", 32'(lp_p), 32'(e_lp_p));
            check("lp_n", 32'(lp_n), 32'(e_lp_n));
        end
        check("busy",     32'(busy),     32'(ph != P_STOP));
        check("underrun", 32'(underrun), 32'(e_under));
        check("s_ready",  32'(s_ready),  32'(mq.size() < DEPTH));
        if (underrun === 1'b1) und_total++;
    end

    // ---------------------------------------------------------- helpers
    int rdy_low = 0;

    // Called just after a falling edge; returns just after the falling edge
    // that follows the accepting rising edge.
    task automatic send(input logic [DW-1:0] d, input logic l);
        int guard = 0;
        s_valid = 1'b1; s_data = d; s_last = l;
        while (!s_ready && guard < 200) begin
            rdy_low++;
            @(negedge clk_base);
            guard++;
        end
        if (guard >= 200) check("send_timeout", 32'd0, 32'd1);
        @(negedge clk_base);
        s_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (!(ph == P_STOP && mq.size() == 0) && guard < 500) begin
            @(negedge clk_base);
            guard++;
        end
        if (guard >= 500) check("idle_timeout", 32'd0, 32'd1);
        repeat (2) @(negedge clk_base);
    endtask

    // Counts busy cycles over the next n falling edges.
    task automatic count_busy(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_base);
            if (busy === 1'b1) cnt++;
        end
    endtask

    // ---------------------------------------------------------- stimulus
    int bcnt;
    int u0;
    int guard;

    initial begin
        repeat (3) @(negedge clk_base);
        reset_n = 1'b1;
        @(negedge clk_base);

        // Single beat, hand-worked timeline (cycle n = after edge n).
        send(16'h1234, 1'b1);
        bcnt = 0;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk_base);
            if (busy === 1'b1) bcnt++;
            case (n)
                1:  begin check("lit_lpx_p", 32'(lp_p), 0); check("lit_lpx_n", 32'(lp_n), 1); end
                3:  begin check("lit_prep_p", 32'(lp_p), 0); check("lit_prep_n", 32'(lp_n), 0); end
                4:  begin check("lit_zero_oe", 32'(hs_oe), 1); check("lit_zero_hs", 32'(hs_data), 0); end
                7:  check("lit_sync", 32'(hs_data), 32'h1D1D);
                8:  check("lit_data", 32'(hs_data), 32'h1234);
                9:  check("lit_trail0", 32'(hs_data), 32'hFFFF);
                10: check("lit_trail1", 32'(hs_data), 32'hFFFF);
                11: begin check("lit_exit_oe", 32'(hs_oe), 0); check("lit_exit_p", 32'(lp_p), 1); end
                13: check("lit_stop_busy", 32'(busy), 0);
                default: ;
            endcase
        end
        check("lit_burst_len", 32'(bcnt), 32'd12);
        wait_idle();

        // Six beats with valid held: FIFO fills, no underrun.
        rdy_low = 0; u0 = und_total;
        for (int i = 0; i < 6; i++) send(16'(16'h1111 * (i + 1)), i == 5);
        wait_idle();
        check("lit_ready_dropped", 32'(rdy_low > 0), 32'd1);
        check("lit_no_underrun", 32'(und_total - u0), 32'd0);

        // Upstream stall after two of five beats.
        u0 = und_total;
        send(16'hA1A2, 1'b0);
        send(16'hB3B4, 1'b0);
        repeat (25) @(negedge clk_base);
        send(16'hC5C6, 1'b0);
        send(16'hD7D8, 1'b0);
        send(16'hE9EA, 1'b1);
        wait_idle();
        check("lit_one_underrun", 32'(und_total - u0), 32'd1);

        // All timing inputs zero: every timed state lasts one cycle.
        t_lpx = 0; t_prep = 0; t_zero = 0; t_trail = 0; t_exit = 0;
        send(16'h5A5B, 1'b1);
        count_busy(20, bcnt);
        check("lit_zero_timing_len", 32'(bcnt), 32'd7);
        wait_idle();

        // Reset in the middle of DATA.
        t_lpx = 2; t_prep = 1; t_zero = 3; t_trail = 2; t_exit = 2;
        send(16'h0102, 1'b0);
        send(16'h0304, 1'b0);
        send(16'h0506, 1'b0);
        guard = 0;
        while (ph != P_DATA && guard < 100) begin @(negedge clk_base); guard++; end
        check("reach_data", 32'(ph), P_DATA);
        #1 reset_n = 1'b0;
        #1;
        check("rst_hs_oe", 32'(hs_oe), 0);
        check("rst_hs_data", 32'(hs_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_lp", 32'({lp_p, lp_n, lp_oe}), 32'b111);
        check("rst_ready", 32'(s_ready), 1);
        @(negedge clk_base);
        reset_n = 1'b1;
        repeat (3) @(negedge clk_base);
        check("rst_fifo_empty", 32'(busy), 0);
        send(16'h7778, 1'b1);
        count_busy(20, bcnt);
        check("lit_restart_len", 32'(bcnt), 32'd12);
        wait_idle();

        // t_zero changed during ZERO only affects the next burst.
        send(16'h1357, 1'b1);
        bcnt = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk_base);
            if (busy === 1'b1) bcnt++;
            if (ph == P_ZERO) t_zero = 8'd6;
        end
        check("lit_latched_len", 32'(bcnt), 32'd12);
        wait_idle();
        send(16'h2468, 1'b1);
        count_busy(30, bcnt);
        check("lit_new_zero_len", 32'(bcnt), 32'd15);
        wait_idle();

        // Randomised traffic and timing, checked every cycle by the model.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_base);
            s_valid = ($urandom_range(0, 2) != 0);
            s_data  = 16'($urandom());
            s_last  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) begin
                t_lpx   = 8'($urandom_range(0, 4));
                t_prep  = 8'($urandom_range(0, 4));
                t_zero  = 8'($urandom_range(0, 4));
                t_trail = 8'($urandom_range(0, 4));
                t_exit  = 8'($urandom_range(0, 4));
            end
        end
        @(negedge clk_base);
        s_valid = 1'b0;
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
